// File: rtl/mac_pkg.sv
// Shared types and width helpers for the dot-product accumulator and its requantiser.
package mac_pkg;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } side_t;

  function automatic int prod_w(input int wx, input int wk);
    return wx + wk;
  endfunction

  function automatic int tree_w(input int wx, input int wk, input int n);
    return wx + wk + $clog2(n);
  endfunction

  function automatic int shift_w(input int wa);
    return $clog2(wa);
  endfunction

endpackage

// File: rtl/mac_requant.sv
// Registered requantiser: round-half-up arithmetic shift, optional ReLU, saturate to WO.
module mac_requant import mac_pkg::*; #(
  parameter int WA = 32,
  parameter int WO = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic signed [WA-1:0]     acc,
  input  logic [shift_w(WA)-1:0]   shift,
  input  logic                     relu,
  output logic                     y_valid,
  output logic signed [WO-1:0]     y,
  output logic                     sat
);

  // One guard bit so the rounding bias can never overflow the accumulator range.
  localparam logic signed [WA:0] YMAX = {{(WA-WO+2){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [WA:0] YMIN = {{(WA-WO+2){1'b1}}, {(WO-1){1'b0}}};

  logic signed [WA:0]   bias;
  logic signed [WA:0]   rounded;
  logic signed [WA:0]   clipped;
  logic signed [WO-1:0] y_next;
  logic                 sat_next;

  always_comb begin
    bias = '0;
    if (shift != '0) bias = (WA+1)'(1) << (shift - 1'b1);
    rounded  = ($signed({acc[WA-1], acc}) + bias) >>> shift;
    clipped  = (relu && rounded < 0) ? '0 : rounded;
    sat_next = 1'b0;
    y_next   = clipped[WO-1:0];
    if (clipped > YMAX) begin
      y_next   = YMAX[WO-1:0];
      sat_next = 1'b1;
    end else if (clipped < YMIN) begin
      y_next   = YMIN[WO-1:0];
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      y_valid <= 1'b0;
      y       <= '0;
      sat     <= 1'b0;
    end else if (en) begin
      y_valid <= in_valid;
      sat     <= in_valid && sat_next;
      if (in_valid) y <= y_next;
    end
  end

endmodule

// File: rtl/n_delay.sv
// Enable-gated delay line of D registers, W bits wide; D=0 is a plain wire.
module n_delay #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (D == 0) begin : g_wire
      assign q = d;
    end else begin : g_pipe
      logic [W-1:0] stage [D];

      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int i = 0; i < D; i++) stage[i] <= '0;
        end else if (en) begin
          stage[0] <= d;
          for (int i = 1; i < D; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[D-1];
    end
  endgenerate

endmodule

// File: rtl/mac_dot_acc.sv
// N-lane signed dot-product accumulator: pipelined products, adder tree,
// packet accumulation on first/last, then requantisation of each packet sum.
module mac_dot_acc import mac_pkg::*; #(
  parameter int N  = 4,
  parameter int WX = 4,
  parameter int WK = 8,
  parameter int LM = 2,
  parameter int WA = 32,
  parameter int WO = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic                     x_valid,
  input  logic                     first,
  input  logic                     last,
  input  logic [N*WX-1:0]          x,
  input  logic [N*WK-1:0]          k,
  input  logic [shift_w(WA)-1:0]   shift,
  input  logic                     relu,
  output logic                     y_valid,
  output logic signed [WO-1:0]     y,
  output logic                     sat
);

  localparam int WP = prod_w(WX, WK);
  localparam int WT = tree_w(WX, WK, N);

  typedef logic signed [WP-1:0] prod_lanes_t [N];

  prod_lanes_t          prod_m1;
  prod_lanes_t          prod_mt;
  side_t                side_in;
  side_t                side_m;
  side_t                t_side;
  logic signed [WT-1:0] tree_sum;
  logic signed [WT-1:0] t_sum;
  logic signed [WA-1:0] acc;
  logic                 a_done;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) prod_m1[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < N; i++)
        prod_m1[i] <= WP'($signed(x[i*WX +: WX])) * WP'($signed(k[i*WK +: WK]));
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_tail
    n_delay #(.W(WP), .D(LM-1)) u_tail (
      .clk  (clk),
      .rstn (rstn),
      .en   (en),
      .d    (prod_m1[i]),
      .q    (prod_mt[i])
    );
  end

  // Sidebands travel the full multiplier depth so they line up with the tail outputs.
  assign side_in = '{valid: x_valid, first: first, last: last};

  n_delay #(.W($bits(side_t)), .D(LM)) u_side (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .d    (side_in),
    .q    (side_m)
  );

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < N; i++) tree_sum = tree_sum + WT'(prod_mt[i]);
  end

  // Accumulator wraps at WA; a first always restarts, even inside an open packet.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      t_sum  <= '0;
      t_side <= '0;
      acc    <= '0;
      a_done <= 1'b0;
    end else if (en) begin
      t_sum  <= tree_sum;
      t_side <= side_m;
      a_done <= t_side.valid && t_side.last;
      if (t_side.valid) acc <= t_side.first ? WA'(t_sum) : acc + WA'(t_sum);
    end
  end

  mac_requant #(.WA(WA), .WO(WO)) u_requant (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .in_valid (a_done),
    .acc      (acc),
    .shift    (shift),
    .relu     (relu),
    .y_valid  (y_valid),
    .y        (y),
    .sat      (sat)
  );

endmodule

// File: tb/tb_mac_dot_acc.sv
// Randomised and directed bench for mac_dot_acc against a packet-level arithmetic model.
module tb_mac_dot_acc;

  localparam int N    = 4;
  localparam int WX   = 4;
  localparam int WK   = 8;
  localparam int LM   = 2;
  localparam int WA   = 32;
  localparam int WO   = 16;
  localparam int SW   = $clog2(WA);
  localparam int MAXC = 128;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 en = 1'b0;
  logic                 x_valid = 1'b0;
  logic                 first = 1'b0;
  logic                 last = 1'b0;
  logic [N*WX-1:0]      x = '0;
  logic [N*WK-1:0]      k = '0;
  logic [SW-1:0]        shift = '0;
  logic                 relu = 1'b0;
  logic                 y_valid;
  logic signed [WO-1:0] y;
  logic                 sat;

  int checks = 0;
  int errors = 0;

  logic [N*WX-1:0] sx [MAXC];
  logic [N*WK-1:0] sk [MAXC];
  bit sv [MAXC];
  bit sf [MAXC];
  bit sl [MAXC];
  bit se [MAXC];
  int ncyc;

  int oy [$];
  bit os [$];
  int ot [$];
  int ey [$];
  bit es [$];
  int et [$];

  localparam logic [N*WX-1:0] X1234 = {4'sd4, 4'sd3, 4'sd2, 4'sd1};
  localparam logic [N*WX-1:0] X7    = {N{4'sd7}};
  localparam logic [N*WX-1:0] XM8   = {N{4'h8}};
  localparam logic [N*WK-1:0] K1    = {N{8'sd1}};
  localparam logic [N*WK-1:0] KM128 = {N{8'h80}};
  localparam logic [N*WK-1:0] K127  = {N{8'sd127}};

  mac_dot_acc #(.N(N), .WX(WX), .WK(WK), .LM(LM), .WA(WA), .WO(WO)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .x_valid (x_valid),
    .first   (first),
    .last    (last),
    .x       (x),
    .k       (k),
    .shift   (shift),
    .relu    (relu),
    .y_valid (y_valid),
    .y       (y),
    .sat     (sat)
  );

  always #5 clk = ~clk;

  function automatic longint dot(input logic [N*WX-1:0] xv, input logic [N*WK-1:0] kv);
    longint s = 0;
    for (int i = 0; i < N; i++) begin
      logic signed [WX-1:0] xi;
      logic signed [WK-1:0] ki;
      xi = xv[i*WX +: WX];
      ki = kv[i*WK +: WK];
      s += longint'(xi) * longint'(ki);
    end
    return s;
  endfunction

  function automatic int requant(input longint a, input int sh, input bit rl, output bit s);
    longint r;
    longint ymax = (longint'(1) << (WO-1)) - 1;
    longint ymin = -(longint'(1) << (WO-1));
    r = (a + ((sh > 0) ? (longint'(1) << (sh-1)) : longint'(0))) >>> sh;
    if (rl && r < 0) r = 0;
    s = 1'b0;
    if (r > ymax) begin r = ymax; s = 1'b1; end
    else if (r < ymin) begin r = ymin; s = 1'b1; end
    return int'(r);
  endfunction

  // Expected results and sample cycle: LM+3 enabled edges after the last beat,
  // held over any disabled cycles until the consumer can see it.
  task automatic build_expected();
    longint acc = 0;
    ey.delete(); es.delete(); et.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (se[c] && sv[c]) begin
        acc = sf[c] ? dot(sx[c], sk[c]) : acc + dot(sx[c], sk[c]);
        acc = (acc <<< (64-WA)) >>> (64-WA);
        if (sl[c]) begin
          bit s;
          int cnt = 0;
          int m = c;
          int t;
          ey.push_back(requant(acc, int'(shift), relu, s));
          es.push_back(s);
          while (cnt < LM+2 && m < ncyc) begin
            m++;
            if (m < ncyc && se[m]) cnt++;
          end
          t = m + 1;
          while (t < ncyc && !se[t]) t++;
          et.push_back(t);
        end
      end
    end
  endtask

  task automatic clear_seq(input int n);
    for (int c = 0; c < MAXC; c++) begin
      sx[c] = '0; sk[c] = '0; sv[c] = 0; sf[c] = 0; sl[c] = 0; se[c] = 1;
    end
    ncyc = n;
  endtask

  task automatic put_beat(input int c, input bit f, input bit l,
                          input logic [N*WX-1:0] xv, input logic [N*WK-1:0] kv);
    sv[c] = 1; sf[c] = f; sl[c] = l; sx[c] = xv; sk[c] = kv;
  endtask

  task automatic run_seq();
    oy.delete(); os.delete(); ot.delete();
    for (int c = 0; c < ncyc; c++) begin
      en = se[c]; x_valid = sv[c]; first = sf[c]; last = sl[c]; x = sx[c]; k = sk[c];
      @(negedge clk);
      if (y_valid && en) begin
        oy.push_back(int'(y)); os.push_back(sat); ot.push_back(c);
      end
      @(posedge clk);
      #1;
    end
    en = 1'b1; x_valid = 1'b0; first = 1'b0; last = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (y_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset y_valid: got %b, expected 0", y_valid); end
    checks++; if (y !== '0) begin errors++; $display("[TB] FAIL reset y: got %0d, expected 0", y); end
    checks++; if (sat !== 1'b0) begin errors++; $display("[TB] FAIL reset sat: got %b, expected 0", sat); end
    @(posedge clk);
    #1;
    rstn = 1'b1; en = 1'b1;
  endtask

  task automatic test_single();
    shift = '0; relu = 1'b0;
    clear_seq(14);
    put_beat(1, 1, 1, X1234, K1);
    build_expected();
    run_seq();
    checks++; if (oy.size() != ey.size()) begin errors++; $display("[TB] FAIL single pulses: got %0d, expected %0d", oy.size(), ey.size()); end
    for (int i = 0; i < ey.size() && i < oy.size(); i++) begin
      checks++; if (oy[i] !== ey[i]) begin errors++; $display("[TB] FAIL single y[%0d]: got %0d, expected %0d", i, oy[i], ey[i]); end
      checks++; if (os[i] !== es[i]) begin errors++; $display("[TB] FAIL single sat[%0d]: got %0d, expected %0d", i, os[i], es[i]); end
      checks++; if (ot[i] !== et[i]) begin errors++; $display("[TB] FAIL single time[%0d]: got %0d, expected %0d", i, ot[i], et[i]); end
    end
    if (oy.size() > 0) begin
      checks++; if (oy[0] !== 10) begin errors++; $display("[TB] FAIL single y_const: got %0d, expected 10", oy[0]); end
      checks++; if (ot[0] !== 1 + LM + 3) begin errors++; $display("[TB] FAIL single latency: got %0d, expected %0d", ot[0], 1 + LM + 3); end
    end
  endtask

  task automatic test_three_beat();
    for (int run = 0; run < 2; run++) begin
      shift = SW'(4); relu = (run == 1);
      clear_seq(16);
      put_beat(1, 1, 0, X7, KM128);
      put_beat(2, 0, 0, X7, KM128);
      put_beat(3, 0, 1, X7, KM128);
      build_expected();
      run_seq();
      checks++; if (oy.size() != ey.size()) begin errors++; $display("[TB] FAIL three_beat pulses: got %0d, expected %0d", oy.size(), ey.size()); end
      for (int i = 0; i < ey.size() && i < oy.size(); i++) begin
        checks++; if (oy[i] !== ey[i]) begin errors++; $display("[TB] FAIL three_beat y relu=%0d: got %0d, expected %0d", run, oy[i], ey[i]); end
        checks++; if (os[i] !== es[i]) begin errors++; $display("[TB] FAIL three_beat sat relu=%0d: got %0d, expected %0d", run, os[i], es[i]); end
        checks++; if (ot[i] !== et[i]) begin errors++; $display("[TB] FAIL three_beat time relu=%0d: got %0d, expected %0d", run, ot[i], et[i]); end
      end
      if (oy.size() > 0) begin
        checks++; if (oy[0] !== ((run == 1) ? 0 : -672)) begin errors++; $display("[TB] FAIL three_beat y_const relu=%0d: got %0d", run, oy[0]); end
      end
    end
    relu = 1'b0;
  endtask

  task automatic test_saturation();
    for (int run = 0; run < 2; run++) begin
      shift = '0; relu = 1'b0;
      clear_seq(22);
      for (int b = 0; b < 10; b++) put_beat(1 + b, b == 0, b == 9, (run == 0) ? X7 : XM8, K127);
      build_expected();
      run_seq();
      checks++; if (oy.size() != ey.size()) begin errors++; $display("[TB] FAIL saturation pulses: got %0d, expected %0d", oy.size(), ey.size()); end
      for (int i = 0; i < ey.size() && i < oy.size(); i++) begin
        checks++; if (oy[i] !== ey[i]) begin errors++; $display("[TB] FAIL saturation y run%0d: got %0d, expected %0d", run, oy[i], ey[i]); end
        checks++; if (os[i] !== es[i]) begin errors++; $display("[TB] FAIL saturation sat run%0d: got %0d, expected %0d", run, os[i], es[i]); end
        checks++; if (ot[i] !== et[i]) begin errors++; $display("[TB] FAIL saturation time run%0d: got %0d, expected %0d", run, ot[i], et[i]); end
      end
      if (oy.size() > 0) begin
        checks++; if (oy[0] !== ((run == 0) ? 32767 : -32768) || os[0] !== 1'b1) begin
          errors++; $display("[TB] FAIL saturation const run%0d: got y=%0d sat=%0d", run, oy[0], os[0]);
        end
      end
    end
  endtask

  task automatic test_stall();
    shift = SW'(4); relu = 1'b0;
    clear_seq(24);
    put_beat(1, 1, 0, X7, KM128);
    for (int c = 3; c <= 5; c++) begin
      put_beat(c, 1, 1, X1234, K1);
      se[c] = 0;
    end
    put_beat(6, 0, 0, X7, KM128);
    put_beat(8, 0, 1, X7, KM128);
    se[13] = 0; se[14] = 0;
    build_expected();
    run_seq();
    checks++; if (oy.size() != ey.size()) begin errors++; $display("[TB] FAIL stall pulses: got %0d, expected %0d", oy.size(), ey.size()); end
    for (int i = 0; i < ey.size() && i < oy.size(); i++) begin
      checks++; if (oy[i] !== ey[i]) begin errors++; $display("[TB] FAIL stall y: got %0d, expected %0d", oy[i], ey[i]); end
      checks++; if (os[i] !== es[i]) begin errors++; $display("[TB] FAIL stall sat: got %0d, expected %0d", os[i], es[i]); end
      checks++; if (ot[i] !== et[i]) begin errors++; $display("[TB] FAIL stall time: got %0d, expected %0d", ot[i], et[i]); end
    end
    if (oy.size() > 0) begin
      checks++; if (oy[0] !== -672 || ot[0] !== 15) begin errors++; $display("[TB] FAIL stall const: got y=%0d t=%0d, expected y=-672 t=15", oy[0], ot[0]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int run = 0; run < 2; run++) begin
      shift = '0; relu = 1'b0;
      clear_seq(16);
      if (run == 0) begin
        put_beat(1, 1, 1, X1234, K1);
        put_beat(2, 1, 0, X1234, K1);
        put_beat(3, 0, 1, X1234, K1);
      end else begin
        put_beat(1, 1, 0, X7, K127);
        put_beat(2, 0, 0, X7, K127);
        put_beat(3, 1, 0, X1234, K1);
        put_beat(4, 0, 1, X1234, K1);
      end
      build_expected();
      run_seq();
      checks++; if (oy.size() != ey.size()) begin errors++; $display("[TB] FAIL b2b pulses run%0d: got %0d, expected %0d", run, oy.size(), ey.size()); end
      for (int i = 0; i < ey.size() && i < oy.size(); i++) begin
        checks++; if (oy[i] !== ey[i]) begin errors++; $display("[TB] FAIL b2b y run%0d[%0d]: got %0d, expected %0d", run, i, oy[i], ey[i]); end
        checks++; if (os[i] !== es[i]) begin errors++; $display("[TB] FAIL b2b sat run%0d[%0d]: got %0d, expected %0d", run, i, os[i], es[i]); end
        checks++; if (ot[i] !== et[i]) begin errors++; $display("[TB] FAIL b2b time run%0d[%0d]: got %0d, expected %0d", run, i, ot[i], et[i]); end
      end
      if (oy.size() > 0) begin
        checks++; if (oy[oy.size()-1] !== 20) begin errors++; $display("[TB] FAIL b2b final_y run%0d: got %0d, expected 20", run, oy[oy.size()-1]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    shift = '0; relu = 1'b0;
    clear_seq(3);
    put_beat(0, 1, 0, X7, K127);
    put_beat(1, 0, 0, X7, K127);
    run_seq();
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (y !== '0 || y_valid !== 1'b0 || sat !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid outputs: got y=%0d y_valid=%b sat=%b, expected all 0", y, y_valid, sat);
    end
    rstn = 1'b1;
    @(posedge clk);
    #1;
    clear_seq(12);
    put_beat(0, 1, 1, X1234, K1);
    build_expected();
    run_seq();
    checks++; if (oy.size() != ey.size()) begin errors++; $display("[TB] FAIL reset_mid pulses: got %0d, expected %0d", oy.size(), ey.size()); end
    for (int i = 0; i < ey.size() && i < oy.size(); i++) begin
      checks++; if (oy[i] !== ey[i]) begin errors++; $display("[TB] FAIL reset_mid y: got %0d, expected %0d", oy[i], ey[i]); end
      checks++; if (os[i] !== es[i]) begin errors++; $display("[TB] FAIL reset_mid sat: got %0d, expected %0d", os[i], es[i]); end
      checks++; if (ot[i] !== et[i]) begin errors++; $display("[TB] FAIL reset_mid time: got %0d, expected %0d", ot[i], et[i]); end
    end
    if (oy.size() > 0) begin
      checks++; if (oy[0] !== 10) begin errors++; $display("[TB] FAIL reset_mid y_const: got %0d, expected 10", oy[0]); end
    end
  endtask

  task automatic test_random();
    for (int iter = 0; iter < 8; iter++) begin
      int c = 1;
      int npk = $urandom_range(1, 4);
      shift = SW'($urandom_range(0, 12));
      relu = 1'($urandom_range(0, 1));
      clear_seq(MAXC);
      for (int p = 0; p < npk; p++) begin
        int nb = $urandom_range(1, 5);
        int b = 0;
        while (b < nb) begin
          int r = $urandom_range(0, 5);
          if (r == 0) begin
            put_beat(c, 1'($urandom), 1'($urandom), (N*WX)'($urandom), (N*WK)'($urandom));
            se[c] = 0;
          end else if (r != 1) begin
            put_beat(c, b == 0, b == nb - 1, (N*WX)'($urandom), (N*WK)'($urandom));
            b++;
          end
          c++;
        end
      end
      ncyc = c + 12;
      build_expected();
      run_seq();
      checks++; if (oy.size() != ey.size()) begin errors++; $display("[TB] FAIL random%0d pulses: got %0d, expected %0d", iter, oy.size(), ey.size()); end
      for (int i = 0; i < ey.size() && i < oy.size(); i++) begin
        checks++; if (oy[i] !== ey[i]) begin errors++; $display("[TB] FAIL random%0d y[%0d]: got %0d, expected %0d", iter, i, oy[i], ey[i]); end
        checks++; if (os[i] !== es[i]) begin errors++; $display("[TB] FAIL random%0d sat[%0d]: got %0d, expected %0d", iter, i, os[i], es[i]); end
        checks++; if (ot[i] !== et[i]) begin errors++; $display("[TB] FAIL random%0d time[%0d]: got %0d, expected %0d", iter, i, ot[i], et[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_beat();
    test_saturation();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_dot_acc.md
Name: mac_dot_acc

Overview:
- Multi-lane signed dot-product accumulator.
- Generalises the single-lane multiply and accumulate pair used in the systolic array PEs.
- Each beat: N parallel products (configurable pipeline latency) → one registered adder-tree stage → accumulation across a packet delimited by first/last.
- At last, the sum is requantised (rounding right-shift, optional ReLU, saturation to WO) and emitted with a valid pulse.
- Sits between the PE operand skew buffers and the output AXI-Stream packer.

Parameters:
- N, 4: number of parallel lanes (≥1).
- WX, 4: signed activation width.
- WK, 8: signed weight width.
- LM, 2: multiplier pipeline depth in enabled cycles (≥1).
- WA, 32: accumulator width; must be ≥ WX+WK+clog2(N).
- WO, 16: output width after requantisation (WO ≤ WA).

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- en  in  1  global pipeline enable; 0 freezes every register.
- x_valid  in  1  input beat valid.
- first  in  1  beat starts a packet (qualified by x_valid).
- last  in  1  beat ends a packet (qualified by x_valid).
- x  in  N*WX  signed activations; lane i at [i*WX +: WX].
- k  in  N*WK  signed weights; lane i at [i*WK +: WK].
- shift  in  clog2(WA)  right-shift amount; quasi-static, sampled at the requant stage.
- relu  in  1  clamp negative results to 0; quasi-static.
- y_valid  out  1  one-cycle pulse per packet.
- y  out  WO  signed requantised result.
- sat  out  1  high with y_valid when saturation occurred.

Behaviour:
- Reset: rstn is synchronous, active-low; clock clk. All pipeline, valid and accumulator registers clear to 0. Outputs y=0, y_valid=0, sat=0 from the first clk edge with rstn=0. Reset mid-packet discards the partial sum.
- en=0: nothing advances, including valid/first/last sidebands and y_valid. A y_valid already high stays high while en=0. Consumers sample y_valid&&en.
- Stage M1..MLM: per-lane signed product, WP = WX+WK bits. x_valid/first/last delay alongside.
- Stage T: registered sum of the N products, sign-extended to WP+clog2(N).
- Stage A: on an enabled cycle with valid:
  - acc ← sext(T) if first, else acc + sext(T).
  - Two's-complement wrap at WA; no saturation inside the accumulator.
  - Invalid beats leave acc unchanged.
  - A first without a preceding last silently restarts the accumulation.
  - first && last on the same beat yields a single-beat result.
- Stage R, on the beat where A consumed last:
  - r = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift: round-half-up, arithmetic shift.
  - If relu and r<0, r=0.
  - Saturate to [−2^(WO−1), 2^(WO−1)−1]; sat=1 if clamped.
  - y_valid=1 for one enabled cycle. y holds its last value otherwise; sat is cleared when y_valid=0.
- Latency: LM+3 enabled cycles from the last input beat to y_valid.
- Throughput: one beat per enabled cycle. Back-to-back packets allowed (last then first on the next cycle).
- Packets interleave only sequentially; single accumulator.

Decomposition:
- Shared package mac_pkg holds:
  - localparam functions for WP, WT = WP+clog2(N) and the shift width;
  - a typedef for the lane-unpacked operand arrays;
  - a struct {valid, first, last} for the delayed sideband.
- One natural sub-module, mac_requant: combinational/registered round, shift, ReLU and saturate stage, parametrised by WA and WO. It is reused by the future output packer.
- Reuse the existing n_delay for the multiplier tail and the sideband delay.

Test Plan:
- Single-beat packet: N=4, x={1,2,3,4}, k={1,1,1,1}, first=last=1, shift=0 → y=10, y_valid one cycle exactly 5 cycles later, sat=0.
- 3-beat packet: all x=7, k=−128 (−3584/beat), shift=4 → acc −10752, y=−672, sat=0. Repeat with relu=1 → y=0.
- Saturation: all x=7, k=127 (3556/beat), 10 beats, shift=0 → acc 35560, y=32767, sat=1. Negative mirror x=−8, k=127, 10 beats → y=−32768, sat=1.
- Stall and bubbles:
  - deassert en for 3 cycles mid-packet and insert x_valid=0 gaps in the 3-beat test → identical y=−672;
  - y_valid delayed exactly by the stall count;
  - no extra pulses.
- Back-to-back and restart:
  - packet A (1 beat, sum 10) then packet B (2 beats, 10+10) on consecutive cycles → y=10 then y=20 on consecutive valid pulses;
  - a first re-asserted mid-packet discards prior beats.
- Reset mid-packet: rstn=0 one cycle after beat 2 of 3 → y=0, y_valid=0 next edge; a following fresh 1-beat packet of sum 10 yields y=10.
